// File: rtl/cmd_parser_if.sv
// ----------------------------------------------------------------------------
// cmd_parser_if
// Groups the byte-input and register-write signals of cmd_parser.
//
// Signals:
//   rx_data    8   received byte, valid while rx_busy is low
//   rx_busy    1   UART receiver busy flag; 1->0 marks a completed byte
//   wr_en      1   one-cycle register-write strobe
//   wr_addr    4   register address, held between frames
//   wr_data    32  register write value, held between frames
//   clr_all    1   one-cycle clear-all-registers strobe
//   frame_err  1   one-cycle rejected/aborted frame strobe
//   in_frame   1   high while a frame is partially received
//   state_dbg  2   current parser FSM state (debug visibility)
//
// Modports:
//   slave  - the parser (consumes rx_*, produces the rest)
//   master - the byte source / register-file side
// ----------------------------------------------------------------------------
interface cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_all;
    logic        frame_err;
    logic        in_frame;
    logic [1:0]  state_dbg;

    modport slave (
        input  rx_data, rx_busy,
        output wr_en, wr_addr, wr_data, clr_all, frame_err, in_frame, state_dbg
    );

    modport master (
        output rx_data, rx_busy,
        input  wr_en, wr_addr, wr_data, clr_all, frame_err, in_frame, state_dbg
    );
endinterface

// File: rtl/cmd_parser.sv
// ----------------------------------------------------------------------------
// cmd_parser
// Parses framed register commands arriving byte by byte from a UART receiver.
// Frame: command byte, then 4 data bytes MSB first (plus an XOR checksum byte
// when CMD_PARSER_CHECKSUM_EN is defined). Commands below NUM_REGS write a
// register, 0x0F clears all registers, anything else is rejected.
//
// Parameters:
//   TIMEOUT_CYCLES  max clk cycles allowed between bytes of one frame
//   NUM_REGS        number of writable register addresses (0..NUM_REGS-1)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   cmd_parser_if.slave (rx_data/rx_busy in; wr_en, wr_addr, wr_data,
//         clr_all, frame_err, in_frame, state_dbg out)
//
// Build option:
//   CMD_PARSER_CHECKSUM_EN  adds a 6th checksum byte (XOR of bytes 1..5)
// ----------------------------------------------------------------------------
module cmd_parser #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int NUM_REGS       = 12
) (
    input  logic         clk,
    input  logic         rst,
    cmd_parser_if.slave  bus
);

`ifdef CMD_PARSER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, EXEC = 2'd2, CHK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, EXEC = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic        prev_busy_q;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] gap_q, gap_d;
    logic        wr_en_q, wr_en_d;
    logic        clr_q, clr_d;
    logic        ferr_q, ferr_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
`ifdef CMD_PARSER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic byte_stb;
    logic in_frame_w;
    logic timeout;
    logic do_exec;

    // A byte completes on the falling edge of rx_busy.
    assign byte_stb   = prev_busy_q && !bus.rx_busy;
`ifdef CMD_PARSER_CHECKSUM_EN
    assign in_frame_w = (state_q == DATA) || (state_q == CHK);
`else
    assign in_frame_w = (state_q == DATA);
`endif
    assign timeout    = in_frame_w && (gap_q >= TIMEOUT_CYCLES[31:0]);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        clr_d   = 1'b0;
        ferr_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        do_exec = 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        // Gap counter only runs mid-frame; any accepted byte restarts it.
        gap_d = (byte_stb || !in_frame_w) ? 32'd0 : gap_q + 32'd1;

        case (state_q)
            // EXEC behaves like IDLE for incoming bytes: no back-pressure.
            IDLE, EXEC: begin
                state_d = IDLE;
                if (byte_stb) begin
                    state_d = DATA;
                    cmd_d   = bus.rx_data;
                    buf_d   = 32'd0;
                    cnt_d   = 2'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
                    xor_d   = bus.rx_data;
`endif
                end
            end
            DATA: begin
                // Byte has priority over a simultaneous timeout.
                if (byte_stb) begin
                    buf_d = {buf_q[23:0], bus.rx_data};
                    cnt_d = cnt_q + 2'd1;
`ifdef CMD_PARSER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
                    if (cnt_q == 2'd3) state_d = CHK;
`else
                    if (cnt_q == 2'd3) do_exec = 1'b1;
`endif
                end else if (timeout) begin
                    state_d = IDLE;
                    buf_d   = 32'd0;
                    ferr_d  = 1'b1;
                end
            end
`ifdef CMD_PARSER_CHECKSUM_EN
            CHK: begin
                if (byte_stb) begin
                    if (bus.rx_data == xor_q) begin
                        do_exec = 1'b1;
                    end else begin
                        state_d = IDLE;
                        buf_d   = 32'd0;
                        ferr_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    buf_d   = 32'd0;
                    ferr_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobes are registered so they appear the cycle after the final byte.
        if (do_exec) begin
            state_d = EXEC;
            if (cmd_q == 8'h0F) begin
                clr_d = 1'b1;
            end else if ({24'd0, cmd_q} < NUM_REGS[31:0]) begin
                wr_en_d = 1'b1;
                addr_d  = cmd_q[3:0];
                data_d  = buf_d;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_busy_q <= 1'b0;
            cmd_q       <= 8'd0;
            buf_q       <= 32'd0;
            cnt_q       <= 2'd0;
            gap_q       <= 32'd0;
            wr_en_q     <= 1'b0;
            clr_q       <= 1'b0;
            ferr_q      <= 1'b0;
            addr_q      <= 4'd0;
            data_q      <= 32'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            prev_busy_q <= bus.rx_busy;
            cmd_q       <= cmd_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            wr_en_q     <= wr_en_d;
            clr_q       <= clr_d;
            ferr_q      <= ferr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef CMD_PARSER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.clr_all   = clr_q;
    assign bus.frame_err = ferr_q;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_data   = data_q;
    assign bus.in_frame  = in_frame_w;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000: maximum number of clk cycles allowed between accepted bytes of one frame.
REQ-002 Parameter NUM_REGS, default 12: number of valid write addresses, 0..NUM_REGS-1.
REQ-003 clk  in  1: single clock; every register of this block is clocked on its rising edge.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 rx_data  in  8: received byte from the upstream UART receiver; valid while rx_busy is low.
REQ-006 rx_busy  in  1: UART receiver busy flag; a 1->0 transition marks one completed byte.
REQ-007 wr_en  out  1: one-cycle register-write strobe.
REQ-008 wr_addr  out  4: register address, held until the next frame completes.
REQ-009 wr_data  out  32: register write value, held until the next frame completes.
REQ-010 clr_all  out  1: one-cycle strobe that clears every register.
REQ-011 frame_err  out  1: one-cycle strobe flagging a rejected or aborted frame.
REQ-012 in_frame  out  1: high while a frame is partially received.

Function
REQ-013 Byte strobe: the block SHALL register rx_busy into prev_busy and accept rx_data on the edge where rx_busy=0 and prev_busy=1.
REQ-014 Frame format: command byte, then 4 data bytes MSB first; total 5 bytes (6 with the checksum option).
REQ-015 FSM states: IDLE, DATA, CHK, EXEC; IDLE -> DATA on the command byte, with the command latched.
REQ-016 DATA: each accepted byte SHALL shift into a 32-bit buffer, buf <= {buf[23:0], rx_data}; a 2-bit counter SHALL count 0..3.
REQ-017 After the 4th data byte: -> CHK if CMD_PARSER_CHECKSUM_EN is defined, otherwise -> EXEC.
REQ-018 EXEC lasts exactly one cycle, then returns to IDLE.
REQ-019 EXEC actions: strobes SHALL be registered and asserted in the cycle after the final byte is accepted (latency 1 clk).
REQ-020 EXEC, command < NUM_REGS: wr_en=1, wr_addr=cmd[3:0], wr_data=buffer.
REQ-021 EXEC, command 0x0F: clr_all=1, wr_en=0; data bytes are ignored.
REQ-022 EXEC, any other command: frame_err=1, no write; wr_addr and wr_data SHALL be unchanged.
REQ-023 Timeout: a 32-bit gap counter SHALL clear on each accepted byte and increment while in DATA or CHK.
REQ-024 When the gap counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse frame_err for 1 cycle and discard the buffer.
REQ-025 Simultaneous timeout and byte acceptance on one edge: the byte SHALL win and the counter SHALL clear.
REQ-026 in_frame SHALL equal 1 in the DATA and CHK states.
REQ-027 All strobes SHALL be low in every cycle other than those specified above.
REQ-028 No back-pressure: a byte arriving during EXEC SHALL be treated as the command byte of the next frame.

Reset
REQ-029 While rst=1: state=IDLE, counters=0, buffer=0, prev_busy=0.
REQ-030 While rst=1: wr_en=0, clr_all=0, frame_err=0, in_frame=0, wr_addr=0, wr_data=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no strobe, including no frame_err.
REQ-032 The first byte after rst deasserts SHALL be treated as a command byte.

Configuration
REQ-033 Macro CMD_PARSER_CHECKSUM_EN defined: a 6th byte is expected, equal to the XOR of the command byte and the 4 data bytes.
REQ-034 With the macro, a checksum match SHALL proceed to EXEC; a mismatch SHALL pulse frame_err, perform no write and return to IDLE.
REQ-035 Without the macro, the CHK state and the XOR accumulator SHALL be absent and frames are 5 bytes.

Verification
REQ-036 Send bytes 02 12 34 56 78, each on a rx_busy 1->0 edge -> one wr_en pulse with wr_addr=2, wr_data=0x12345678, 1 clk after the last byte.
REQ-037 Send 0F 00 00 00 00 -> one clr_all pulse, no wr_en; wr_data keeps its previous value.
REQ-038 Send 0C AA BB CC DD -> frame_err pulse, no wr_en; the next frame 00 00 00 00 01 -> wr_addr=0, wr_data=1.
REQ-039 Send 05 11 22, then idle for TIMEOUT_CYCLES -> frame_err pulse and in_frame=0; next frame 05 00 00 00 09 -> wr_addr=5, wr_data=9.
REQ-040 Assert rst after 3 bytes, release it, send 01 00 00 00 03 -> no strobe during reset; wr_addr=1, wr_data=3.
REQ-041 With CMD_PARSER_CHECKSUM_EN: 03 00 00 00 01 02 -> wr_en; 03 00 00 00 01 FF -> frame_err and no write.
